// File: rtl/left_shift_pipe.sv
// left_shift_pipe: pipelined left barrel shifter, one power-of-two stage per cycle, valid/ready on both sides
// Define LSHIFT_ROTATE_EN to rotate instead of zero-fill shifting; out_ovf is then tied 0.
module left_shift_pipe #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [SHAMT_W-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_o,
   output logic               out_ovf
);
   logic [SHAMT_W-1:0] valid, adv, ld;
   logic [WIDTH-1:0]   data [SHAMT_W];
   logic [WIDTH-1:0]   nd   [SHAMT_W];
   logic [SHAMT_W-1:0] b    [SHAMT_W];
   logic [SHAMT_W-1:0] nb   [SHAMT_W];
   logic [WIDTH-1:0]   sa;
   logic [SHAMT_W-1:0] sb;
   logic               go;
`ifndef LSHIFT_ROTATE_EN
   logic [SHAMT_W-1:0] ovf, novf;
   logic               so;
`endif

   // Readiness ripples from the output back to stage 0; go is "downstream can take a word"
   always_comb begin
      go  = out_ready;
      adv = '0;
      for (int i = SHAMT_W - 1; i >= 0; i--) begin
         adv[i] = valid[i] && go;
         go     = !valid[i] || adv[i];
      end
      in_ready = go;
      ld       = (adv << 1) | SHAMT_W'(in_valid && go);
   end

   // Remaining amount bits are kept MSB-aligned, so every stage tests the MSB
   always_comb begin
      nd = '{default: '0};
      nb = '{default: '0};
      sa = in_a;
      sb = in_b;
`ifndef LSHIFT_ROTATE_EN
      novf = '0;
      so   = 1'b0;
`endif
      for (int i = 0; i < SHAMT_W; i++) begin
`ifdef LSHIFT_ROTATE_EN
         nd[i] = sb[SHAMT_W-1] ? (sa << (1 << (SHAMT_W-1-i))) | (sa >> (WIDTH - (1 << (SHAMT_W-1-i)))) : sa;
`else
         nd[i]   = sb[SHAMT_W-1] ? sa << (1 << (SHAMT_W-1-i)) : sa;
         novf[i] = so | (sb[SHAMT_W-1] && |(sa >> (WIDTH - (1 << (SHAMT_W-1-i)))));
         so      = ovf[i];
`endif
         nb[i] = sb << 1;
         sa    = data[i];
         sb    = b[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
`ifndef LSHIFT_ROTATE_EN
         ovf <= '0;
`endif
         for (int i = 0; i < SHAMT_W; i++) begin
            data[i] <= '0;
            b[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < SHAMT_W; i++) begin
            if (ld[i]) begin
               valid[i] <= 1'b1;
               data[i]  <= nd[i];
               b[i]     <= nb[i];
`ifndef LSHIFT_ROTATE_EN
               ovf[i]   <= novf[i];
`endif
            end else if (adv[i]) begin
               valid[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = valid[SHAMT_W-1];
   assign out_o     = data[SHAMT_W-1];
`ifdef LSHIFT_ROTATE_EN
   assign out_ovf = 1'b0;
`else
   assign out_ovf = ovf[SHAMT_W-1];
`endif
endmodule

// File: tb/tb_left_shift_pipe.sv
// tb_left_shift_pipe: vectors, streaming, backpressure, reset and random traffic against a shift/rotate model
module tb_left_shift_pipe;
   localparam int W = 8;
   localparam int S = 3;

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid, out_ovf;
   logic [W-1:0] in_a = '0, out_o;
   logic [S-1:0] in_b = '0;

   typedef struct {logic [W-1:0] o; logic ovf; int cyc;} exp_t;
   typedef struct {logic [W-1:0] a; logic [S-1:0] b; logic [W-1:0] o; logic ovf;} vec_t;

   exp_t         sbq[$];
   vec_t         tbl[8];
   int           total = 0, bad = 0, cycle = 0;
   logic         acc, emit, lat_chk = 1'b1, last_ovf;
   logic [W-1:0] last_o, d_a;
   logic [S-1:0] d_b;

   left_shift_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [S-1:0] b);
      logic [2*W-1:0] w;
      exp_t e;
      w = {{W{1'b0}}, a} << b;
`ifdef LSHIFT_ROTATE_EN
      e.o   = w[W-1:0] | w[2*W-1:W];
      e.ovf = 1'b0;
`else
      e.o   = w[W-1:0];
      e.ovf = |w[2*W-1:W];
`endif
      e.cyc = cycle;
      return e;
   endfunction

   task automatic cyc(input logic v, input logic [W-1:0] a, input logic [S-1:0] b, input logic ordy);
      exp_t e;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      #1;
      acc  = v && in_ready;
      emit = out_valid && ordy;
      if (emit) begin
         if (sbq.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            e = sbq.pop_front();
            chk("out_o", out_o, e.o);
            chk("out_ovf", out_ovf, e.ovf);
            if (lat_chk) chk("latency", cycle - e.cyc, S);
            last_o   = out_o;
            last_ovf = out_ovf;
         end
      end
      if (acc) sbq.push_back(model(a, b));
      @(negedge clk);
      cycle++;
   endtask

   task automatic drain();
      repeat (8) cyc(1'b0, '0, '0, 1'b1);
      chk("drained", sbq.size(), 0);
   endtask

   initial begin
`ifdef LSHIFT_ROTATE_EN
      tbl = '{'{8'h01, 3'd3, 8'h08, 1'b0}, '{8'hF0, 3'd4, 8'h0F, 1'b0}, '{8'h0F, 3'd4, 8'hF0, 1'b0},
              '{8'h81, 3'd1, 8'h03, 1'b0}, '{8'hA5, 3'd4, 8'h5A, 1'b0}, '{8'hFF, 3'd0, 8'hFF, 1'b0},
              '{8'h80, 3'd7, 8'h40, 1'b0}, '{8'h01, 3'd7, 8'h80, 1'b0}};
`else
      tbl = '{'{8'h01, 3'd3, 8'h08, 1'b0}, '{8'hF0, 3'd4, 8'h00, 1'b1}, '{8'h0F, 3'd4, 8'hF0, 1'b0},
              '{8'h81, 3'd1, 8'h02, 1'b1}, '{8'hA5, 3'd4, 8'h50, 1'b1}, '{8'hFF, 3'd0, 8'hFF, 1'b0},
              '{8'h80, 3'd7, 8'h00, 1'b1}, '{8'h01, 3'd7, 8'h80, 1'b0}};
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_o", out_o, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         int n;
         cyc(1'b1, tbl[i].a, tbl[i].b, 1'b1);
         chk("vec_accept", acc, 1);
         n = 0;
         do begin
            cyc(1'b0, '0, '0, 1'b1);
            n++;
         end while (!emit && n < 10);
         chk("vec_emitted", emit, 1);
         chk("vec_o", last_o, tbl[i].o);
         chk("vec_ovf", last_ovf, tbl[i].ovf);
      end

      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, W'($urandom), S'(i), 1'b1);
         chk("stream_in_ready", acc, 1);
      end
      drain();

      lat_chk = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d_a = W'($urandom) | 8'h01;
         d_b = S'(i + 1);
         cyc(1'b1, d_a, d_b, 1'b0);
         chk("bp_accept", acc, i < 3);
      end
      repeat (2) begin
         cyc(1'b0, '0, '0, 1'b0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_hold_o", out_o, sbq[0].o);
         chk("bp_hold_ovf", out_ovf, sbq[0].ovf);
      end
      cyc(1'b1, d_a, d_b, 1'b1);
      chk("bp_late_accept", acc, 1);
      chk("bp_first_drain", emit, 1);
      drain();

      lat_chk = 1'b1;
      cyc(1'b1, 8'h11, 3'd2, 1'b1);
      cyc(1'b1, 8'h22, 3'd5, 1'b1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_o", out_o, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      drain();
      cyc(1'b1, 8'h3C, 3'd1, 1'b1);
      drain();

      lat_chk = 1'b0;
      for (int i = 0; i < 300; i++)
         cyc($urandom % 4 != 0, W'($urandom), S'($urandom), $urandom % 3 != 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
